// File: rtl/cpu_pkg.sv
// Shared constants and types for the cpu_sequencer slice: widths, opcodes,
// instruction field positions and sequencer state encoding.
package cpu_pkg;

  localparam int WORD_W    = 20;
  localparam int MEM_DEPTH = 32;

  localparam logic [4:0] OP_NOP  = 5'd0;
  localparam logic [4:0] OP_BEQZ = 5'd29;
  localparam logic [4:0] OP_JMP  = 5'd30;
  localparam logic [4:0] OP_HALT = 5'd31;

  localparam int FIELD_W    = 5;
  localparam int OPC_LSB    = 0;
  localparam int ADDR_A_LSB = 5;
  localparam int ADDR_B_LSB = 10;
  localparam int ADDR_W_LSB = 15;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE    = 3'd0;
  localparam state_t ST_FETCH   = 3'd1;
  localparam state_t ST_DECODE  = 3'd2;
  localparam state_t ST_EXECUTE = 3'd3;
  localparam state_t ST_WB      = 3'd4;
  localparam state_t ST_HALTED  = 3'd5;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/cpu_sequencer_if.sv
// Control/status bundle between the sequencer and its program memory,
// ALU and register file; master drives the inputs of the sequencer.
interface cpu_sequencer_if #(
  parameter int WORD_W = 20
) ();
  logic              start;
  logic              stop;
  logic [WORD_W-1:0] instr;
  logic              alu_done;
  logic              alu_zero;
  logic [WORD_W-1:0] pc;
  logic [WORD_W-1:0] ir;
  logic              alu_start;
  logic [4:0]        alu_op;
  logic [31:0]       reg_we;
  logic              busy;
  logic              halted;
  logic [15:0]       retired;

  modport master (
    output start, stop, instr, alu_done, alu_zero,
    input  pc, ir, alu_start, alu_op, reg_we, busy, halted, retired
  );

  modport slave (
    input  start, stop, instr, alu_done, alu_zero,
    output pc, ir, alu_start, alu_op, reg_we, busy, halted, retired
  );
endinterface

// File: rtl/wb_decoder.sv
// 5-to-32 one-hot decoder with enable; drives the register write strobes.
module wb_decoder (
  input  logic        en,
  input  logic [4:0]  sel,
  output logic [31:0] onehot
);

  always_comb begin
    onehot = '0;
    if (en) onehot[sel] = 1'b1;
  end

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle instruction sequencer: fetch/decode/execute/writeback with
// ALU handshake, stop-at-boundary request and saturating retire counter.
//
//   state      | meaning
//   -----------+--------------------------------------------------------
//   ST_IDLE    | not running; start launches from pc 0
//   ST_FETCH   | latch instr into ir
//   ST_DECODE  | dispatch: HALT/JMP/BEQZ/NOP finish here, others to ALU
//   ST_EXECUTE | alu_start on entry cycle, then wait for alu_done
//   ST_WB      | one-hot write strobe, pc advance, retire
//   ST_HALTED  | stopped by HALT; start relaunches from pc 0
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter int WORD_W    = cpu_pkg::WORD_W,
  parameter int MEM_DEPTH = cpu_pkg::MEM_DEPTH
) (
  input  logic            clk,
  input  logic            rst_n,
  cpu_sequencer_if.slave  bus
);

  localparam logic [4:0] PC_LAST = 5'(MEM_DEPTH - 1);

  state_t            state;
  logic [4:0]        pc_q;
  logic [WORD_W-1:0] ir_q;
  logic [15:0]       retired_q;
  logic              zflag;
  logic              stop_pend;
  logic              exec_first;

  logic [4:0] opcode;
  logic [4:0] addr_w;
  logic [4:0] pc_seq;
  logic       busy_int;

  assign opcode   = ir_q[OPC_LSB +: FIELD_W];
  assign addr_w   = ir_q[ADDR_W_LSB +: FIELD_W];
  assign pc_seq   = (pc_q == PC_LAST) ? 5'd0 : pc_q + 5'd1;
  assign busy_int = (state == ST_FETCH) || (state == ST_DECODE) ||
                    (state == ST_EXECUTE) || (state == ST_WB);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      pc_q       <= 5'd0;
      ir_q       <= '0;
      retired_q  <= 16'd0;
      zflag      <= 1'b0;
      stop_pend  <= 1'b0;
      exec_first <= 1'b0;
    end else begin
      // Later assignments in the case below (IDLE entry, start) override this.
      if (busy_int && bus.stop) stop_pend <= 1'b1;
      exec_first <= 1'b0;

      case (state)
        ST_IDLE, ST_HALTED: begin
          if (bus.start) begin
            pc_q      <= 5'd0;
            retired_q <= 16'd0;
            zflag     <= 1'b0;
            stop_pend <= 1'b0;
            state     <= ST_FETCH;
          end
        end

        ST_FETCH: begin
          ir_q  <= bus.instr;
          state <= ST_DECODE;
        end

        ST_DECODE: begin
          case (opcode)
            OP_HALT: state <= ST_HALTED;
            OP_JMP, OP_BEQZ, OP_NOP: begin
              if (opcode == OP_JMP || (opcode == OP_BEQZ && zflag))
                pc_q <= addr_w;
              else
                pc_q <= pc_seq;
              retired_q <= sat_inc16(retired_q);
              if (stop_pend) begin
                stop_pend <= 1'b0;
                state     <= ST_IDLE;
              end else begin
                state <= ST_FETCH;
              end
            end
            default: begin
              exec_first <= 1'b1;
              state      <= ST_EXECUTE;
            end
          endcase
        end

        ST_EXECUTE: begin
          // The launch cycle never completes, even if alu_done is already high.
          if (!exec_first && bus.alu_done) begin
            zflag <= bus.alu_zero;
            state <= ST_WB;
          end
        end

        ST_WB: begin
          pc_q      <= pc_seq;
          retired_q <= sat_inc16(retired_q);
          if (stop_pend) begin
            stop_pend <= 1'b0;
            state     <= ST_IDLE;
          end else begin
            state <= ST_FETCH;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

  wb_decoder u_wb_decoder (
    .en     (state == ST_WB),
    .sel    (addr_w),
    .onehot (bus.reg_we)
  );

  assign bus.pc        = {{(WORD_W-5){1'b0}}, pc_q};
  assign bus.ir        = ir_q;
  assign bus.alu_start = (state == ST_EXECUTE) && exec_first;
  assign bus.alu_op    = (state == ST_EXECUTE) ? opcode : 5'd0;
  assign bus.busy      = busy_int;
  assign bus.halted    = (state == ST_HALTED);
  assign bus.retired   = retired_q;

endmodule
